// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: streams a RAM region out of the read port on a valid/ready interface,
// hiding the one-cycle read latency behind a 2-entry output buffer.
module dpram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    input  logic                  dout_ready
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   issue_rem, out_rem;
    logic                  inflight, rd_ptr, wr_ptr, pop, issue;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] buf_q [2];

    assign pop        = dout_valid & dout_ready;
    // Buffered words plus the pending read must leave room for the new read's data.
    assign issue      = (state == RUN) && (issue_rem != '0) &&
                        (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign ram_addr   = addr_cnt;
    assign dout_valid = count != 2'd0;
    assign dout_data  = buf_q[rd_ptr];
    assign dout_last  = dout_valid && (out_rem == ONE);
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    always_comb begin
        state_nxt = (state == IDLE)  ? (start ? ((length == '0) ? DONE : RUN) : IDLE) :
                    (state == RUN)   ? ((issue && issue_rem == ONE) ? DRAIN : RUN) :
                    (state == DRAIN) ? ((pop && out_rem == ONE) ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            issue_rem <= '0;
            out_rem   <= '0;
            inflight  <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (state == IDLE && start) begin
                addr_cnt  <= base_addr;
                issue_rem <= length;
                out_rem   <= length;
            end
            if (issue) begin
                addr_cnt  <= addr_cnt + 1'b1;
                issue_rem <= issue_rem - ONE;
            end
            if (inflight) begin
                buf_q[wr_ptr] <= ram_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_rem <= out_rem - ONE;
            end
        end
    end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: scoreboard bench; expected words are queued from the RAM model at start.
module tb_dpram_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done, dout_valid, dout_last;
    logic        dout_ready = 1'b0;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata, dout_data;
    logic [31:0] mem [1024];
    logic [31:0] q [$];
    int tests = 0;
    int fails = 0;

    dpram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .dout_valid(dout_valid), .dout_data(dout_data), .dout_last(dout_last),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic run_burst(input logic [9:0] b, input logic [10:0] l, input int mode,
                             input int inject, input int abort_n,
                             output int first_c, output int last_c);
        int cyc, acc;
        logic stalled, rdy;
        logic [31:0] prev, exp;
        logic [9:0] diff;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        for (int i = 0; i < int'(l); i++) q.push_back(mem[(int'(b) + i) % 1024]);
        first_c = -1;
        last_c = -1;
        acc = 0;
        stalled = 1'b0;
        prev = '0;
        @(negedge clk);
        base_addr = b;
        length = l;
        start = 1'b1;
        for (cyc = 1; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (inject != 0 && cyc == 3) begin
                base_addr = b + 10'd100;
                length = 11'd5;
                start = 1'b1;
            end
            if (inject != 0 && cyc == 4) start = 1'b0;
            if (abort_n > 0 && acc == abort_n) break;
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL early_done: done=%b before final beat, required 0", done);
            end
            rdy = (mode != 0) ? (pat[cyc % 6] != 0) : 1'b1;
            dout_ready = rdy;
            if (stalled) begin
                tests++;
                if (dout_data !== prev) begin
                    fails++;
                    $display("FAIL stall_stable: data=%0d, required %0d", dout_data, prev);
                end
            end
            if (mode != 0) begin
                diff = ram_addr - b;
                tests++;
                if (int'(diff) - acc > 2) begin
                    fails++;
                    $display("FAIL addr_ahead: issued=%0d accepted=%0d, required <=2 ahead", diff, acc);
                end
            end
            if (dout_valid === 1'b1 && first_c < 0) first_c = cyc;
            if (dout_valid === 1'b1 && rdy) begin
                exp = q.pop_front();
                tests++;
                if (dout_data !== exp || dout_last !== (q.size() == 0)) begin
                    fails++;
                    $display("FAIL beat%0d: data=%0d last=%b, required data=%0d last=%b",
                             acc, dout_data, dout_last, exp, q.size() == 0);
                end
                acc++;
                last_c = cyc;
                if (q.size() == 0) break;
            end
            stalled = dout_valid && !rdy;
            prev = dout_data;
        end
        if (cyc >= 4000) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d beats left, required 0", q.size());
            q.delete();
        end else if (abort_n == 0) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b1 || busy !== 1'b1 || dout_valid !== 1'b0) begin
                fails++;
                $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 1 0", done, busy, dout_valid);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_after: done=%b busy=%b, required 0 0", done, busy);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0 || dout_last !== 1'b0 ||
            dout_data !== 32'd0 || ram_addr !== 10'd0) begin
            fails++;
            $display("FAIL %s: busy=%b done=%b valid=%b last=%b data=%0d addr=%0d, required all 0",
                     tag, busy, done, dout_valid, dout_last, dout_data, ram_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int f, l;
        run_burst(10'd5, 11'd4, 0, 0, 0, f, l);
        tests++;
        if (f !== 3 || l - f !== 3) begin
            fails++;
            $display("FAIL basic_timing: first=%0d span=%0d, required 3 and 3", f, l - f);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        run_burst(10'd5, 11'd4, 1, 0, 0, f, l);
    endtask

    task automatic test_wrap();
        int f, l;
        run_burst(10'd1022, 11'd4, 0, 0, 0, f, l);
    endtask

    task automatic test_zero();
        @(negedge clk);
        base_addr = 10'd9;
        length = 11'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b valid=%b, required 1 0", done, dout_valid);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle: done=%b busy=%b valid=%b, required 0 0 0", done, busy, dout_valid);
        end
    endtask

    task automatic test_full();
        int f, l;
        run_burst(10'd7, 11'd1024, 0, 0, 0, f, l);
        tests++;
        if (l - f !== 1023) begin
            fails++;
            $display("FAIL full_span: span=%0d, required 1023", l - f);
        end
    endtask

    task automatic test_start_busy();
        int f, l;
        run_burst(10'd100, 11'd8, 0, 1, 0, f, l);
        run_burst(10'd300, 11'd3, 0, 0, 0, f, l);
    endtask

    task automatic test_reset_mid();
        int f, l;
        run_burst(10'd20, 11'd8, 0, 0, 2, f, l);
        rst_n = 1'b0;
        #1 check_reset_vals("reset_mid");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(10'd0, 11'd4, 0, 0, 0, f, l);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i * 3;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_full();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Streaming read engine for the one-bit-slice `dual_port_ram` arrays that the memory techmap builds. Given a base address and a word count, it drives the RAM's read port (`addr2`/`out2`, write-disabled) and returns the words in address order on a valid/ready stream. It is the read-side counterpart to the write-only port A, and lets PRGA fabric logic and testbenches dump or consume a RAM region without hand-scheduling the one-cycle read latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, RAM address width; matches the mapped RAM (10..15).
- `DATA_WIDTH`, 32, word width; matches the mapped RAM (32..1).

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a burst; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; captured with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `ram_addr`  out  ADDR_WIDTH  drives the RAM read address (`addr2`).
- `ram_rdata`  in  DATA_WIDTH  RAM read data (`out2`); valid one cycle after the address is sampled.
- `dout_valid`  out  1  stream word available.
- `dout_data`  out  DATA_WIDTH  stream word.
- `dout_last`  out  1  qualifies the final word of a burst.
- `dout_ready`  in  1  consumer accepts the word when this and `dout_valid` are both high.

## Operation
- States:
  - IDLE: waits for a burst request.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the buffer and in-flight read to empty.
  - DONE: one cycle; `done` = 1.
- IDLE → RUN: `start`=1 and `length`≠0. On entry: `addr_cnt`=`base_addr`, `issue_rem`=`length`, `out_rem`=`length`.
- IDLE → DONE: `start`=1 and `length`=0. No reads are issued and no beats are produced.
- RUN → DRAIN: the edge that issues the read that brings `issue_rem` to 0.
- DRAIN → DONE: `out_rem` reaches 0 (last beat accepted).
- DONE → IDLE: unconditional.
- `start` is ignored outside IDLE.
- `ram_addr` = `addr_cnt`, a register.
- A read is issued at an edge in RUN when both hold:
  - `issue_rem`≠0;
  - occupancy + inflight − pop < 2. Occupancy is the 2-entry output buffer count, inflight is the 1-bit pending-read flag, and pop = `dout_valid`&`dout_ready`.
- On issue: set `inflight`, increment `addr_cnt` modulo 2^ADDR_WIDTH (silent wrap past all-ones to 0), decrement `issue_rem`.
- When `inflight` was set at the previous edge, `ram_rdata` is written into the buffer at this edge.
- The buffer is a 2-entry FIFO.
  - Head drives `dout_data` and `dout_valid`.
  - Push and pop in the same edge are allowed.
  - It never overflows, given the issue rule.
- `dout_last` = `dout_valid` & (`out_rem`==1). `out_rem` decrements on each pop.
- The RAM has no read enable. `ram_addr` may be sampled when no read is issued; such data is discarded.
- `dout_data` stays stable while `dout_valid`&!`dout_ready`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `dout_valid`=0, `dout_last`=0.
  - `dout_data`=0, `ram_addr`=0.
  - Buffer empty, `inflight`=0, state IDLE.
- Reset mid-burst abandons the burst immediately. No `done` is produced.
- Latency, `start` sampled at edge N:
  - first read issued at edge N+1;
  - first `dout_valid` high after edge N+2.
- Throughput: with `dout_ready` held high, 1 word/cycle; a burst of L words occupies edges N+2..N+L+1.
- Completion: `done` is high in the cycle after the edge that accepts the last beat. `busy` falls one cycle later. A new `start` is accepted in that following cycle.
- Stalls: with `dout_ready` low, at most 2 words are buffered and no further reads issue. Resumption needs no bubble beyond the ready-to-pop dependency.

## Test plan
- Basic burst:
  - Stimulus: RAM[i]=i*3, `base_addr`=5, `length`=4, `dout_ready`=1.
  - Response: beats 15,18,21,24 on consecutive cycles starting 2 cycles after start; `dout_last` on 24; `done` next cycle.
- Backpressure:
  - Stimulus: same burst, `dout_ready` toggling 1,0,0,1,0,1…
  - Response: identical sequence with no loss or duplication; `dout_data` stable while stalled; `ram_addr` never more than 2 words ahead of the accepted beats.
- Wrap-around:
  - Stimulus: `ADDR_WIDTH`=10, `base_addr`=1022, `length`=4.
  - Response: words from addresses 1022,1023,0,1 in that order.
- Boundary lengths:
  - `length`=0: `done` pulses 1 cycle after start; `dout_valid` never rises.
  - `length`=1024: all 1024 words, `dout_last` only on the final one.
- Start while busy:
  - Stimulus: assert `start` with a new `base_addr` mid-burst.
  - Response: ignored; the original burst completes unchanged; a `start` after `done` runs normally.
- Reset mid-burst:
  - Stimulus: `rst_n` low after 2 of 8 beats.
  - Response: all outputs at their reset values immediately; no `done`; a next burst from `base_addr`=0 returns correct data.
